// File: rtl/ibex_pkg.sv
// Shared types for the bounds-check unit: access kinds, CSR layouts, FSM states.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package ibex_pkg;

  localparam int unsigned BCPNumRegions = 4;

  typedef enum logic [1:0] {
    BCP_LOAD  = 2'd0,
    BCP_STORE = 2'd1,
    BCP_ARITH = 2'd2
  } bcp_acc_e;

  typedef struct packed {
    logic       en;
    logic       r;
    logic       w;
    logic [4:0] size;
  } bcp_cfg_t;

  typedef struct packed {
    logic en;
  } bcp_mseccfg_t;

  typedef enum logic [1:0] {
    BCP_IDLE = 2'd0,
    BCP_SCAN = 2'd1,
    BCP_RESP = 2'd2
  } bcp_state_e;

  // Inclusive last byte of an access, kept in 33 bits so a wrap past
  // 0xFFFF_FFFF shows up in bit 32. ARITH checks a single pointer value.
  // Size code 3 is not a legal access size; it is treated as 4 bytes.
  function automatic logic [32:0] bcp_acc_end(input logic [31:0] addr,
                                              input bcp_acc_e    typ,
                                              input logic [1:0]  size);
    logic [32:0] last_off;
    case (size)
      2'd0:    last_off = 33'd0;
      2'd1:    last_off = 33'd1;
      default: last_off = 33'd3;
    endcase
    if (typ == BCP_ARITH) last_off = 33'd0;
    return {1'b0, addr} + last_off;
  endfunction

endpackage

// File: rtl/ibex_bcp_region_match.sv
// Single-region bounds comparison: does the access range fit inside one region.
// Latency: purely combinational.
// Backpressure: none; the caller chooses which region to present each cycle.
// Build option: IBEX_BCP_PERM_EN adds the r/w permission requirement to a hit.
module ibex_bcp_region_match
  import ibex_pkg::*;
(
  input  logic [31:0] base,
  input  bcp_cfg_t    cfg,
  input  logic [31:0] acc_start,
  input  logic [32:0] acc_end,
  input  bcp_acc_e    acc_type,
  output logic        hit
);

  logic [32:0] region_end;
  logic        perm_ok;

  // Exclusive region end in 33 bits. The size field is 5 bits wide, so the
  // largest region is 2^31 bytes and the 2^32 case cannot be encoded.
  assign region_end = {1'b0, base} + (33'd1 << cfg.size);

`ifdef IBEX_BCP_PERM_EN
  // Loads need read, stores need write; pointer arithmetic needs neither.
  always_comb begin
    perm_ok = 1'b1;
    if (acc_type == BCP_LOAD)  perm_ok = cfg.r;
    if (acc_type == BCP_STORE) perm_ok = cfg.w;
  end
`else
  logic unused_perm;
  assign unused_perm = ^{cfg.r, cfg.w, acc_type};
  assign perm_ok     = 1'b1;
`endif

  // An access that wrapped past the top of the address space never hits.
  assign hit = cfg.en & ~acc_end[32] & (acc_start >= base) &
               (acc_end < region_end) & perm_ok;

endmodule

// File: rtl/ibex_bcp_checker.sv
// Bounds-check unit: scans enabled regions one per cycle for one containing the access.
// Latency: hit at region k -> T+2+k, miss -> T+1+NumRegions, checker disabled -> T+1.
// Backpressure: req_ready_o only in IDLE; the response holds until rsp_ready_i.
// Build option: IBEX_BCP_PERM_EN (see ibex_bcp_region_match) makes r/w bits gate hits.
module ibex_bcp_checker
  import ibex_pkg::*;
#(
  parameter int unsigned NumRegions = BCPNumRegions,
  localparam int unsigned RegW      = (NumRegions > 1) ? $clog2(NumRegions) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [31:0]        req_addr_i,
  input  bcp_acc_e           req_type_i,
  input  logic [1:0]         req_size_i,
  input  logic               flush_i,
  input  logic [31:0]        csr_bcp_addr_i [NumRegions],
  input  bcp_cfg_t           csr_bcp_cfg_i  [NumRegions],
  input  bcp_mseccfg_t       csr_bcp_mseccfg_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic               rsp_err_o,
  output logic [RegW-1:0]    rsp_region_o,
  output logic               bcp_load_addr_err_o,
  output logic               bcp_store_addr_err_o,
  output logic               bcp_arith_addr_err_o
);

  localparam logic [RegW-1:0] LastIdx = RegW'(NumRegions - 1);

  bcp_state_e      state_q, state_d;
  logic [RegW-1:0] idx_q, idx_d;
  logic [RegW-1:0] region_q, region_d;
  logic            err_q, err_d;
  logic [31:0]     addr_q;
  bcp_acc_e        type_q;
  logic [1:0]      size_q;
  logic            accept;
  logic            hit;
  logic [32:0]     acc_end;

  // Flush takes priority, so a request offered alongside it is not taken.
  assign accept  = (state_q == BCP_IDLE) & req_valid_i & ~flush_i;
  assign acc_end = bcp_acc_end(addr_q, type_q, size_q);

  // One comparator shared across regions; CSRs are read live at the scan index.
  ibex_bcp_region_match u_region_match (
    .base      (csr_bcp_addr_i[idx_q]),
    .cfg       (csr_bcp_cfg_i[idx_q]),
    .acc_start (addr_q),
    .acc_end   (acc_end),
    .acc_type  (type_q),
    .hit       (hit)
  );

  // State, scan index, result and captured request registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= BCP_IDLE;
      idx_q    <= '0;
      region_q <= '0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      type_q   <= BCP_LOAD;
      size_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      region_q <= region_d;
      err_q    <= err_d;
      if (accept) begin
        addr_q <= req_addr_i;
        type_q <= req_type_i;
        size_q <= req_size_i;
      end
    end
  end

  // Next-state: scan regions in index order, first hit wins, miss after the last.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    region_d = region_q;
    unique case (state_q)
      BCP_IDLE: begin
        if (req_valid_i) begin
          if (csr_bcp_mseccfg_i.en) begin
            state_d = BCP_SCAN;
            idx_d   = '0;
          end else begin
            state_d  = BCP_RESP;
            err_d    = 1'b0;
            region_d = '0;
          end
        end
      end
      BCP_SCAN: begin
        if (hit) begin
          state_d  = BCP_RESP;
          err_d    = 1'b0;
          region_d = idx_q;
        end else if (idx_q == LastIdx) begin
          state_d  = BCP_RESP;
          err_d    = 1'b1;
          region_d = '0;
        end else begin
          idx_d = idx_q + RegW'(1);
        end
      end
      BCP_RESP: begin
        if (rsp_ready_i) state_d = BCP_IDLE;
      end
      default: state_d = BCP_IDLE;
    endcase
    if (flush_i) state_d = BCP_IDLE;
  end

  // Outputs are forced low while reset is held, even if state is stale.
  assign req_ready_o          = (state_q == BCP_IDLE) & ~rst_i;
  assign rsp_valid_o          = (state_q == BCP_RESP) & ~rst_i;
  assign rsp_err_o            = rsp_valid_o & err_q;
  assign rsp_region_o         = rsp_valid_o ? region_q : '0;
  assign bcp_load_addr_err_o  = rsp_err_o & (type_q == BCP_LOAD);
  assign bcp_store_addr_err_o = rsp_err_o & (type_q == BCP_STORE);
  assign bcp_arith_addr_err_o = rsp_err_o & (type_q == BCP_ARITH);

endmodule

// File: tb/tb_ibex_bcp_checker.sv
// Self-checking bench for ibex_bcp_checker: vector table plus directed sequences.
// Latency: responses are timed from the acceptance cycle.
// Backpressure: exercises response stalls, flush and reset mid-operation.
module tb_ibex_bcp_checker;
  import ibex_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [31:0]  req_addr;
  bcp_acc_e     req_type;
  logic [1:0]   req_size;
  logic         flush;
  logic [31:0]  csr_addr [4];
  bcp_cfg_t     csr_cfg  [4];
  bcp_mseccfg_t mseccfg;
  logic         rsp_valid, rsp_ready, rsp_err;
  logic [1:0]   rsp_region;
  logic         load_err, store_err, arith_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          phase;
    logic [31:0] addr;
    bcp_acc_e    typ;
    logic [1:0]  size;
    logic        err;
    logic [1:0]  region;
    int          lat;
    string       name;
  } vec_t;

  typedef struct {
    logic       err;
    logic [1:0] region;
    int         lat;
    bcp_acc_e   typ;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  ibex_bcp_checker dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .req_valid_i          (req_valid),
    .req_ready_o          (req_ready),
    .req_addr_i           (req_addr),
    .req_type_i           (req_type),
    .req_size_i           (req_size),
    .flush_i              (flush),
    .csr_bcp_addr_i       (csr_addr),
    .csr_bcp_cfg_i        (csr_cfg),
    .csr_bcp_mseccfg_i    (mseccfg),
    .rsp_valid_o          (rsp_valid),
    .rsp_ready_i          (rsp_ready),
    .rsp_err_o            (rsp_err),
    .rsp_region_o         (rsp_region),
    .bcp_load_addr_err_o  (load_err),
    .bcp_store_addr_err_o (store_err),
    .bcp_arith_addr_err_o (arith_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addv(input int ph, input logic [31:0] a, input bcp_acc_e t,
                      input logic [1:0] s, input logic e, input logic [1:0] r,
                      input int lat, input string name);
    vec_t v;
    v.phase = ph; v.addr = a; v.typ = t; v.size = s;
    v.err = e; v.region = r; v.lat = lat; v.name = name;
    vecs.push_back(v);
  endtask

  // Region configurations used by the table and the directed sequences.
  task automatic set_phase(input int p);
    for (int i = 0; i < 4; i++) begin
      csr_addr[i] = 32'h0;
      csr_cfg[i]  = '{en: 1'b0, r: 1'b1, w: 1'b1, size: 5'd0};
    end
    mseccfg.en = 1'b1;
    case (p)
      0, 4: begin
        csr_addr[0] = 32'h1000;
        csr_cfg[0]  = '{en: 1'b1, r: 1'b1, w: 1'b1, size: 5'd8};
        if (p == 4) mseccfg.en = 1'b0;
      end
      1: begin
        csr_cfg[2]  = '{en: 1'b1, r: 1'b1, w: 1'b1, size: 5'd12};
      end
      2: begin
        csr_addr[1] = 32'h2000;
        csr_cfg[1]  = '{en: 1'b1, r: 1'b1, w: 1'b1, size: 5'd4};
        csr_addr[3] = 32'h2000;
        csr_cfg[3]  = '{en: 1'b1, r: 1'b1, w: 1'b1, size: 5'd8};
      end
      default: begin
        csr_addr[0] = 32'h8000_0000;
        csr_cfg[0]  = '{en: 1'b1, r: 1'b1, w: 1'b1, size: 5'd31};
      end
    endcase
  endtask

  // Offer a request; it is accepted at the next rising edge. The request
  // inputs are scrambled afterwards to show they were captured.
  task automatic issue(input logic [31:0] a, input bcp_acc_e t, input logic [1:0] s,
                       input bit push, input logic e, input logic [1:0] r,
                       input int lat, input string name);
    exp_t x;
    req_valid = 1'b1;
    req_addr  = a;
    req_type  = t;
    req_size  = s;
    if (push) begin
      x.err = e; x.region = r; x.lat = lat; x.typ = t; x.name = name;
      sb.push_back(x);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = ~a;
    req_type  = (t == BCP_LOAD) ? BCP_ARITH : BCP_LOAD;
    req_size  = ~s;
  endtask

  // Wait for the response (bounded), compare against the scoreboard head,
  // optionally stall it for `hold` cycles, then consume it.
  task automatic await_rsp(input int elapsed, input int hold);
    exp_t x;
    int   lat;
    bit   seen;
    lat  = elapsed;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: response seen with no expectation queued");
      return;
    end
    x = sb.pop_front();
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s timeout: no rsp_valid by cycle T+%0d, expected T+%0d", x.name, lat, x.lat);
      return;
    end
    chk({x.name, " latency"}, lat, x.lat);
    chk({x.name, " err"}, rsp_err, x.err);
    chk({x.name, " region"}, rsp_region, x.region);
    chk({x.name, " load_err"}, load_err, x.err & (x.typ == BCP_LOAD));
    chk({x.name, " store_err"}, store_err, x.err & (x.typ == BCP_STORE));
    chk({x.name, " arith_err"}, arith_err, x.err & (x.typ == BCP_ARITH));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({x.name, " hold valid"}, rsp_valid, 1'b1);
      chk({x.name, " hold err"}, rsp_err, x.err);
      chk({x.name, " hold region"}, rsp_region, x.region);
      chk({x.name, " hold ready_o"}, req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  cur;
    bit  any_valid;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_type = BCP_LOAD; req_size = '0;
    flush = 1'b0; rsp_ready = 1'b0;
    set_phase(0);

    //           ph  addr          type       sz  err region lat name
    addv(0, 32'h0000_10FC, BCP_LOAD,  2'd2, 1'b0, 2'd0, 2, "ld4_in");
    addv(0, 32'h0000_10FE, BCP_LOAD,  2'd2, 1'b1, 2'd0, 5, "ld4_over");
    addv(0, 32'h0000_10FF, BCP_STORE, 2'd0, 1'b0, 2'd0, 2, "st1_top");
    addv(0, 32'h0000_1100, BCP_ARITH, 2'd0, 1'b1, 2'd0, 5, "ar_end");
    addv(0, 32'h0000_0FFF, BCP_LOAD,  2'd1, 1'b1, 2'd0, 5, "ld2_below");
    addv(0, 32'h0000_1000, BCP_STORE, 2'd1, 1'b0, 2'd0, 2, "st2_base");
    addv(1, 32'h0000_0FFF, BCP_ARITH, 2'd0, 1'b0, 2'd2, 4, "ar_r2");
    addv(1, 32'h0000_1000, BCP_LOAD,  2'd0, 1'b1, 2'd0, 5, "ld1_r2_out");
    addv(1, 32'h0000_0FFC, BCP_STORE, 2'd2, 1'b0, 2'd2, 4, "st4_r2");
    addv(2, 32'h0000_2000, BCP_LOAD,  2'd2, 1'b0, 2'd1, 3, "low_idx_wins");
    addv(2, 32'h0000_200E, BCP_LOAD,  2'd2, 1'b0, 2'd3, 5, "r3_hit");
    addv(2, 32'h0000_20FF, BCP_ARITH, 2'd0, 1'b0, 2'd3, 5, "ar_r3_top");
    addv(3, 32'hFFFF_FFFE, BCP_STORE, 2'd2, 1'b1, 2'd0, 5, "st_wrap");
    addv(3, 32'hFFFF_FFFF, BCP_LOAD,  2'd0, 1'b0, 2'd0, 2, "ld_last_byte");
    addv(3, 32'hFFFF_FFFF, BCP_ARITH, 2'd0, 1'b0, 2'd0, 2, "ar_last");
    addv(4, 32'h0000_10FE, BCP_LOAD,  2'd2, 1'b0, 2'd0, 1, "disabled");

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", req_ready, 1'b0);
    chk("rst rsp_valid", rsp_valid, 1'b0);
    chk("rst rsp_err", rsp_err, 1'b0);
    chk("rst rsp_region", rsp_region, 2'd0);
    chk("rst err_flags", {load_err, store_err, arith_err}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst req_ready", req_ready, 1'b1);
    @(posedge clk); #1;

    // Vector table.
    cur = 0;
    foreach (vecs[i]) begin
      if (vecs[i].phase != cur) begin
        set_phase(vecs[i].phase);
        cur = vecs[i].phase;
      end
      issue(vecs[i].addr, vecs[i].typ, vecs[i].size, 1'b1,
            vecs[i].err, vecs[i].region, vecs[i].lat, vecs[i].name);
      await_rsp(1, 0);
    end

    // Disabled checker with a 3-cycle response stall.
    set_phase(4);
    issue(32'h0000_5000, BCP_STORE, 2'd2, 1'b1, 1'b0, 2'd0, 1, "dis_stall");
    await_rsp(1, 3);

    // A request waiting during the response is not taken in the release cycle.
    issue(32'h0000_5000, BCP_STORE, 2'd2, 1'b0, 1'b0, 2'd0, 1, "");
    @(negedge clk);
    chk("release rsp_valid", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h10FC; req_type = BCP_LOAD; req_size = 2'd2;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("no_same_cycle_accept valid", rsp_valid, 1'b0);
    chk("no_same_cycle_accept ready", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("next_cycle_accept valid", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Flush in T+2 of a scan, next request accepted in T+3.
    set_phase(0);
    issue(32'h0000_10FE, BCP_LOAD, 2'd2, 1'b0, 1'b0, 2'd0, 0, "");
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush T+2 rsp_valid", rsp_valid, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush T+3 req_ready", req_ready, 1'b1);
    chk("flush T+3 rsp_valid", rsp_valid, 1'b0);
    issue(32'h0000_10FC, BCP_LOAD, 2'd2, 1'b1, 1'b0, 2'd0, 2, "after_flush");
    await_rsp(1, 0);

    // Flush beats a simultaneous request in IDLE.
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h10FC; req_type = BCP_LOAD; req_size = 2'd2;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("flush_beats_req ready", req_ready, 1'b1);

    // CSRs are live: region 0 rewrite after it was compared has no effect,
    // region 3 rewrite before its turn produces the hit.
    @(posedge clk); #1;
    issue(32'h0000_3000, BCP_LOAD, 2'd0, 1'b1, 1'b0, 2'd3, 5, "csr_live");
    @(posedge clk); #1;
    csr_addr[0] = 32'h3000;
    csr_addr[3] = 32'h3000;
    csr_cfg[3]  = '{en: 1'b1, r: 1'b1, w: 1'b1, size: 5'd4};
    await_rsp(2, 0);
    set_phase(0);

    // Reset mid-scan discards the operation.
    issue(32'h0000_10FE, BCP_LOAD, 2'd2, 1'b0, 1'b0, 2'd0, 0, "");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_scan req_ready", req_ready, 1'b0);
    chk("rst_scan rsp_valid", rsp_valid, 1'b0);
    chk("rst_scan outputs", {rsp_err, rsp_region, load_err, store_err, arith_err}, 6'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    any_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_valid |= rsp_valid;
    end
    chk("rst_scan no response", any_valid, 1'b0);
    chk("rst_scan idle after", req_ready, 1'b1);

    // Reset while a response is pending discards it.
    @(posedge clk); #1;
    set_phase(4);
    issue(32'h0000_5000, BCP_ARITH, 2'd0, 1'b0, 1'b0, 2'd0, 0, "");
    @(negedge clk);
    chk("rst_resp pending", rsp_valid, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    any_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_valid |= rsp_valid;
    end
    chk("rst_resp dropped", any_valid, 1'b0);

    chk("scoreboard empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
